// File: rtl/resp_sweep_checker.sv
// Exhaustive response sweep: drives every WIDTH-bit vector to a DUT, holds each for
// SETTLE cycles, samples the 1-bit response and scores it against a latched golden table.
module resp_sweep_checker #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [(1<<WIDTH)-1:0]   golden,
  input  logic                    dut_out,
  output logic [WIDTH-1:0]        vec,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [(1<<WIDTH)-1:0]   captured,
  output logic [WIDTH:0]          mismatch_cnt,
  output logic [WIDTH-1:0]        first_fail,
  output logic                    fail_seen
);

  localparam int N     = 1 << WIDTH;
  localparam int S_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW    = $clog2(S_EFF + 1);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(N - 1);
  localparam logic [CW-1:0]    RELOAD  = CW'(S_EFF);
  localparam logic [WIDTH:0]   CNT_MAX = (WIDTH+1)'(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   golden_q;
  logic [CW-1:0]  settle;
  logic           accept, sample, last, miss;

  assign busy = (state == RUN);
  assign miss = dut_out != golden_q[vec];

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort outranks a sample falling on the same edge: the pending vector is not scored
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN: if (abort) begin
        state_nxt = IDLE;
      end else if (settle == CW'(1)) begin
        sample = 1'b1;
        if (vec == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      golden_q     <= '0;
      settle       <= '0;
      vec          <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      captured     <= '0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      fail_seen    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        golden_q     <= golden;
        captured     <= '0;
        mismatch_cnt <= '0;
        first_fail   <= '0;
        fail_seen    <= 1'b0;
        pass         <= 1'b0;
        vec          <= '0;
        settle       <= RELOAD;
      end else if (state == RUN) begin
        if (abort) begin
          pass <= 1'b0;
          vec  <= '0;
        end else if (sample) begin
          captured[vec] <= dut_out;
          if (miss) begin
            if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!fail_seen) begin
              first_fail <= vec;
              fail_seen  <= 1'b1;
            end
          end
          if (last) begin
            vec  <= '0;
            pass <= (mismatch_cnt == '0) && !miss;
          end else begin
            vec    <= vec + 1'b1;
            settle <= RELOAD;
          end
        end else begin
          settle <= settle - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_resp_sweep_checker.sv
// Bench for resp_sweep_checker: SETTLE=1 and SETTLE=3 instances share stimulus; a
// time-based sweep model is compared every cycle, plus literal checks of known sweeps.
module tb_resp_sweep_checker;

  logic       CK = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] golden = 8'h96;
  logic [1:0] mode = 2'd0;
  logic [2:0] fault_v = 3'd0;
  logic [7:0] rnd_tab = 8'h00;

  logic       dout   [2];
  logic [2:0] vec_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [7:0] cap_o  [2];
  logic [3:0] cnt_o  [2];
  logic [2:0] ff_o   [2];
  logic       fs_o   [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 CK = ~CK;

  // DUT behaviour: 0 parity, 1 parity with one inverted vector, 2 stuck-at-0, 3 table
  function automatic logic resp(input logic [2:0] v, input logic [1:0] md,
                                input logic [2:0] fv, input logic [7:0] tab);
    case (md)
      2'd0:    return ^v;
      2'd1:    return (^v) ^ (v == fv);
      2'd2:    return 1'b0;
      default: return tab[v];
    endcase
  endfunction

  assign dout[0] = resp(vec_o[0], mode, fault_v, rnd_tab);
  assign dout[1] = resp(vec_o[1], mode, fault_v, rnd_tab);

  resp_sweep_checker #(.WIDTH(3), .SETTLE(1)) dut0 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .golden(golden),
    .dut_out(dout[0]), .vec(vec_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .captured(cap_o[0]), .mismatch_cnt(cnt_o[0]),
    .first_fail(ff_o[0]), .fail_seen(fs_o[0]));

  resp_sweep_checker #(.WIDTH(3), .SETTLE(3)) dut1 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .golden(golden),
    .dut_out(dout[1]), .vec(vec_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .captured(cap_o[1]), .mismatch_cnt(cnt_o[1]),
    .first_fail(ff_o[1]), .fail_seen(fs_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- model: a sweep is "m_t cycles since start" ----------------
  logic       m_run  [2];
  int         m_t    [2];
  logic [7:0] m_gl   [2];
  logic [7:0] m_cap  [2];
  logic [3:0] m_cnt  [2];
  logic [2:0] m_ff   [2];
  logic       m_fs   [2];
  logic       m_pass [2];
  logic       m_done [2];
  logic [2:0] ev     [2];
  logic       samp   [2];
  logic       md     [2];
  logic       mmis   [2];

  function automatic int sof(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      ev[g]   = '0;
      samp[g] = 1'b0;
      md[g]   = 1'b0;
      mmis[g] = 1'b0;
      if (m_run[g] === 1'b1) begin
        ev[g]   = 3'(m_t[g] / sof(g));
        samp[g] = !abort && (((m_t[g] + 1) % sof(g)) == 0);
        md[g]   = resp(ev[g], mode, fault_v, rnd_tab);
        mmis[g] = md[g] != m_gl[g][ev[g]];
      end
    end
  end

  always @(posedge CK or negedge reset) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset) begin
        m_run[g] <= 1'b0; m_t[g] <= 0; m_gl[g] <= '0; m_cap[g] <= '0; m_cnt[g] <= '0;
        m_ff[g] <= '0; m_fs[g] <= 1'b0; m_pass[g] <= 1'b0; m_done[g] <= 1'b0;
      end else begin
        m_done[g] <= 1'b0;
        if (!m_run[g]) begin
          if (start) begin
            m_run[g] <= 1'b1; m_t[g] <= 0; m_gl[g] <= golden; m_cap[g] <= '0;
            m_cnt[g] <= '0; m_ff[g] <= '0; m_fs[g] <= 1'b0; m_pass[g] <= 1'b0;
          end
        end else if (abort) begin
          m_run[g]  <= 1'b0;
          m_pass[g] <= 1'b0;
        end else begin
          m_t[g] <= m_t[g] + 1;
          if (samp[g]) begin
            m_cap[g][ev[g]] <= md[g];
            if (mmis[g]) begin
              m_cnt[g] <= m_cnt[g] + 4'd1;
              if (!m_fs[g]) begin
                m_ff[g] <= ev[g];
                m_fs[g] <= 1'b1;
              end
            end
            if (ev[g] == 3'd7) begin
              m_run[g]  <= 1'b0;
              m_done[g] <= 1'b1;
              m_pass[g] <= (m_cnt[g] == 4'd0) && !mmis[g];
            end
          end
        end
      end
    end
  end

  always @(negedge CK) begin
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("m_vec%0d", g),  vec_o[g],  ev[g]);
      chk($sformatf("m_busy%0d", g), busy_o[g], m_run[g]);
      chk($sformatf("m_done%0d", g), done_o[g], m_done[g]);
      chk($sformatf("m_pass%0d", g), pass_o[g], m_pass[g]);
      chk($sformatf("m_cap%0d", g),  cap_o[g],  m_cap[g]);
      chk($sformatf("m_cnt%0d", g),  cnt_o[g],  m_cnt[g]);
      chk($sformatf("m_ff%0d", g),   ff_o[g],   m_ff[g]);
      chk($sformatf("m_fs%0d", g),   fs_o[g],   m_fs[g]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CK);
    #2;
  endtask

  task automatic run_sweep(input int repulse_at, output int lat0, output int lat1);
    bit pulsed = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int c = 1; c <= 60 && (lat0 < 0 || lat1 < 0); c++) begin
      step();
      start = 1'b0;
      if (done_o[0] && lat0 < 0) lat0 = c;
      if (done_o[1] && lat1 < 0) lat1 = c;
      if (repulse_at >= 0 && !pulsed && busy_o[0] && vec_o[0] == 3'(repulse_at)) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string nm, input logic [7:0] cap, input int cnt,
                              input int ff, input logic fs, input logic ps);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_cap%0d", nm, g),  cap_o[g],  cap);
      chk($sformatf("%s_cnt%0d", nm, g),  cnt_o[g],  cnt);
      chk($sformatf("%s_ff%0d", nm, g),   ff_o[g],   ff);
      chk($sformatf("%s_fs%0d", nm, g),   fs_o[g],   fs);
      chk($sformatf("%s_pass%0d", nm, g), pass_o[g], ps);
    end
  endtask

  initial begin
    int l0, l1;
    step();
    for (int g = 0; g < 2; g++) begin
      chk("rst_vec", vec_o[g], 0);
      chk("rst_busy", busy_o[g], 0);
      chk("rst_cap", cap_o[g], 0);
      chk("rst_cnt", cnt_o[g], 0);
    end
    step();
    reset = 1'b1;
    step();

    mode = 2'd0; golden = 8'h96;
    run_sweep(-1, l0, l1);
    chk("parity_lat_s1", l0, 8);
    chk("parity_lat_s3", l1, 24);
    check_result("parity", 8'h96, 0, 0, 1'b0, 1'b1);

    mode = 2'd1; fault_v = 3'd5;
    run_sweep(-1, l0, l1);
    check_result("fault5", 8'hB6, 1, 5, 1'b1, 1'b0);

    mode = 2'd2;
    run_sweep(-1, l0, l1);
    check_result("stuck0", 8'h00, 4, 1, 1'b1, 1'b0);

    mode = 2'd3; rnd_tab = 8'h69;
    run_sweep(-1, l0, l1);
    check_result("allfail", 8'h69, 8, 0, 1'b1, 1'b0);

    mode = 2'd0;
    run_sweep(3, l0, l1);
    chk("repulse_lat_s1", l0, 8);
    chk("repulse_lat_s3", l1, 24);
    check_result("repulse", 8'h96, 0, 0, 1'b0, 1'b1);

    // abort at vec=2, then abort in idle, then start+abort together
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20 && vec_o[0] != 3'd2; c++) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", busy_o[0], 0);
    chk("abort_done", done_o[0], 0);
    chk("abort_pass", pass_o[0], 0);
    chk("abort_cap10", cap_o[0][1:0], 2'b10);
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("idle_abort_cap10", cap_o[0][1:0], 2'b10);
    chk("idle_abort_busy", busy_o[0], 0);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_wins0", busy_o[0], 1);
    chk("start_wins1", busy_o[1], 1);
    for (int c = 0; c < 40 && (busy_o[0] || busy_o[1]); c++) step();
    step();
    chk("after_both_pass", pass_o[1], 1);

    // reset mid-sweep at vec=4
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20 && vec_o[0] != 3'd4; c++) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_vec", vec_o[0], 0);
    chk("mid_rst_busy", busy_o[0], 0);
    chk("mid_rst_cap", cap_o[0], 0);
    chk("mid_rst_done", done_o[0], 0);
    chk("mid_rst_busy1", busy_o[1], 0);
    step(); step();
    reset = 1'b1;
    step();
    run_sweep(-1, l0, l1);
    chk("post_rst_lat", l0, 8);
    check_result("post_rst", 8'h96, 0, 0, 1'b0, 1'b1);

    // random traffic against the model
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        golden  = 8'($urandom);
        mode    = 2'($urandom);
        fault_v = 3'($urandom);
        rnd_tab = ($urandom_range(0, 3) == 0) ? golden : 8'($urandom);
      end
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0;
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
